// File: rtl/skinny_sbox_pkg.sv
// Shared helpers for the masked SKINNY-128 8-bit S-box: bit permutations,
// latency constant and the unmasked reference S-box.
package skinny_sbox_pkg;

  localparam int unsigned SBOX_W       = 8;
  localparam int unsigned SBOX_LATENCY = 8;

  // Inter-round wiring: new[7:0] = {x2,x1,x7,x6,x4,x0,x3,x5}
  function automatic logic [SBOX_W-1:0] perm8(input logic [SBOX_W-1:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  // Final wiring: exchange bits 1 and 2
  function automatic logic [SBOX_W-1:0] swap12(input logic [SBOX_W-1:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  // Unmasked S(x): 3x [MIX, PERM], MIX, SWAP
  function automatic logic [SBOX_W-1:0] sbox_ref(input logic [SBOX_W-1:0] x);
    logic [SBOX_W-1:0] t;
    t = x;
    for (int i = 0; i < 4; i++) begin
      t[0] = t[0] ^ ~(t[3] | t[2]);
      t[4] = t[4] ^ ~(t[7] | t[6]);
      if (i < 3) t = perm8(t);
    end
    return swap12(t);
  endfunction

endpackage

// File: rtl/skinny_isw_and2.sv
// Two-share ISW AND with share-wise XOR accumulate: c0^c1 = (d0^d1) ^ (a0^a1)&(b0^b1).
// Two register layers; all operands must be held stable across both edges.
module skinny_isw_and2 (
  input  logic clk,
  input  logic rst,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic d0,
  input  logic d1,
  input  logic rb,
  output logic c0,
  output logic c1
);

  logic p0_q;
  logic z_q;

  // Layer 1 refreshes both partial products with rb before any share mixing
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q <= 1'b0;
      z_q  <= 1'b0;
      c0   <= 1'b0;
      c1   <= 1'b0;
    end else begin
      p0_q <= (a0 & b0) ^ rb;
      z_q  <= rb ^ (a0 & b1);
      c0   <= p0_q ^ d0;
      c1   <= (a1 & b1) ^ (a1 & b0) ^ z_q ^ d1;
    end
  end

endmodule

// File: rtl/skinny_sbox8_lut.sv
// Unmasked combinational SKINNY-128 8-bit S-box (golden model).
module skinny_sbox8_lut
  import skinny_sbox_pkg::*;
(
  output logic [7:0] so,
  input  logic [7:0] si
);

  always_comb begin
    so = sbox_ref(si);
  end

endmodule

// File: rtl/skinny_sbox8_isw1_np.sv
// First-order masked SKINNY-128 8-bit S-box, two shares, non-pipelined (8 cycles).
// Optional start/done handshake when SKINNY_SBOX_DONE_EN is defined.
module skinny_sbox8_isw1_np
  import skinny_sbox_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
`ifdef SKINNY_SBOX_DONE_EN
  input  logic       start,
  output logic       done,
`endif
  output logic [7:0] so1,
  output logic [7:0] so0,
  input  logic [7:0] si1,
  input  logic [7:0] si0,
  input  logic [7:0] r
);

  localparam int unsigned LATENCY = SBOX_LATENCY;
  localparam int unsigned ROUNDS  = LATENCY / 2;

  logic [ROUNDS-1:0][7:0] st0, st1;
  logic [ROUNDS-1:0][7:0] y0, y1;
  logic [ROUNDS-1:0][5:0] pq0, pq1;
  logic [ROUNDS-1:0]      cx0_s0, cx0_s1, cx4_s0, cx4_s1;

  // Round inputs: raw shares for round 0, permuted previous round otherwise
  always_comb begin
    st0[0] = si0;
    st1[0] = si1;
    for (int k = 1; k < ROUNDS; k++) begin
      st0[k] = perm8(y0[k-1]);
      st1[k] = perm8(y1[k-1]);
    end
  end

  always_comb begin
    for (int k = 0; k < ROUNDS; k++) begin
      y0[k] = {pq0[k][5:3], cx4_s0[k], pq0[k][2:0], cx0_s0[k]};
      y1[k] = {pq1[k][5:3], cx4_s1[k], pq1[k][2:0], cx0_s1[k]};
    end
  end

  // Bits untouched by MIX pass through one register per round
  always_ff @(posedge clk) begin
    if (rst) begin
      pq0 <= '0;
      pq1 <= '0;
    end else begin
      for (int k = 0; k < ROUNDS; k++) begin
        pq0[k] <= {st0[k][7:5], st0[k][3:1]};
        pq1[k] <= {st1[k][7:5], st1[k][3:1]};
      end
    end
  end

  // Masked NOR: complement share 0 of each operand, then ISW AND into the target bit
  for (genvar k = 0; k < ROUNDS; k++) begin : g_rnd
    skinny_isw_and2 u_and_x0 (
      .clk (clk),
      .rst (rst),
      .a0  (~st0[k][3]),
      .a1  (st1[k][3]),
      .b0  (~st0[k][2]),
      .b1  (st1[k][2]),
      .d0  (st0[k][0]),
      .d1  (st1[k][0]),
      .rb  (r[2*k+1]),
      .c0  (cx0_s0[k]),
      .c1  (cx0_s1[k])
    );

    skinny_isw_and2 u_and_x4 (
      .clk (clk),
      .rst (rst),
      .a0  (~st0[k][7]),
      .a1  (st1[k][7]),
      .b0  (~st0[k][6]),
      .b1  (st1[k][6]),
      .d0  (st0[k][4]),
      .d1  (st1[k][4]),
      .rb  (r[2*k]),
      .c0  (cx4_s0[k]),
      .c1  (cx4_s1[k])
    );
  end

  assign so0 = swap12(y0[ROUNDS-1]);
  assign so1 = swap12(y1[ROUNDS-1]);

`ifdef SKINNY_SBOX_DONE_EN
  logic [2:0] cnt;
  logic       busy;

  // done rises on the LATENCY-th edge after start and holds until start/rst
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (cnt == 3'(LATENCY - 1)) begin
        done <= 1'b1;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_skinny_sbox8_isw1_np.sv
// Scoreboard bench for skinny_sbox8_isw1_np; checks start/done too when SKINNY_SBOX_DONE_EN is set.
module tb_skinny_sbox8_isw1_np;

  logic       clk;
  logic       rst;
  logic [7:0] si0, si1, r;
  logic [7:0] so0, so1;
  logic [7:0] lut_si, lut_so;
`ifdef SKINNY_SBOX_DONE_EN
  logic       start;
  logic       done;
`endif

  skinny_sbox8_isw1_np dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SKINNY_SBOX_DONE_EN
    .start (start),
    .done  (done),
`endif
    .so1   (so1),
    .so0   (so0),
    .si1   (si1),
    .si0   (si0),
    .r     (r)
  );

  skinny_sbox8_lut u_lut (
    .so (lut_so),
    .si (lut_si)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       full;
    logic       rec;
    logic [7:0] e0;
    logic [7:0] e1;
    string      name;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rec_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       strobe   = 1'b0;

  // Monitor: pops one expectation whenever the stimulus marks outputs as presented
  always @(negedge clk) begin
    if (strobe) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: output presented with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.full) begin
          if (so0 !== e.e0 || so1 !== e.e1) begin
            n_fail++;
            $display("FAIL %s: so0=%h so1=%h expected so0=%h so1=%h", e.name, so0, so1, e.e0, e.e1);
          end
        end else if ((so0 ^ so1) !== e.e0) begin
          n_fail++;
          $display("FAIL %s: so0^so1=%h expected %h", e.name, so0 ^ so1, e.e0);
        end
        if (e.rec) rec_q.push_back(so0);
      end
    end
  end

  // Called just after a posedge: flag the outputs for the following negedge
  task automatic present();
    strobe = 1'b1;
    @(negedge clk);
    #1 strobe = 1'b0;
  endtask

  task automatic push_exp(input logic full, input logic rec, input logic [7:0] e0,
                          input logic [7:0] e1, input string name);
    exp_t e;
    e.full = full;
    e.rec  = rec;
    e.e0   = e0;
    e.e1   = e1;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic run_vec(input logic [7:0] si, input logic [7:0] m, input logic [7:0] rr,
                         input logic [7:0] exp, input logic rec, input string name);
    si0 = si ^ m;
    si1 = m;
    r   = rr;
    push_exp(1'b0, rec, exp, 8'h00, name);
    repeat (8) @(posedge clk);
    present();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic varied;
    rst    = 1'b1;
    si0    = 8'h00;
    si1    = 8'h00;
    r      = 8'h00;
    lut_si = 8'h00;
`ifdef SKINNY_SBOX_DONE_EN
    start  = 1'b0;
`endif
    @(negedge clk);
    #1;
    @(posedge clk);
    @(posedge clk);
    push_exp(1'b1, 1'b0, 8'h00, 8'h00, "reset_state");
    present();
    rst = 1'b0;

    // Hand-computed directed vectors over several masks and randomness values
    run_vec(8'h00, 8'h00, 8'h00, 8'h65, 1'b0, "s00_m00_r00");
    run_vec(8'h00, 8'hA5, 8'hFF, 8'h65, 1'b0, "s00_mA5_rFF");
    run_vec(8'h01, 8'h00, 8'h00, 8'h4C, 1'b0, "s01_m00_r00");
    run_vec(8'h01, 8'hC3, 8'h5A, 8'h4C, 1'b0, "s01_mC3_r5A");
    run_vec(8'h01, 8'hFF, 8'h81, 8'h4C, 1'b0, "s01_mFF_r81");
    run_vec(8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, "sFF_m00_r00");
    run_vec(8'hFF, 8'h3C, 8'hF0, 8'hFF, 1'b0, "sFF_m3C_rF0");
    run_vec(8'hFF, 8'hA5, 8'h0F, 8'hFF, 1'b0, "sFF_mA5_r0F");

    // Reset in the middle of a run clears both shares on the next edge
    si0 = 8'h01 ^ 8'h5A;
    si1 = 8'h5A;
    r   = 8'h33;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    push_exp(1'b1, 1'b0, 8'h00, 8'h00, "mid_reset");
    present();
    rst = 1'b0;
    run_vec(8'h01, 8'h5A, 8'h33, 8'h4C, 1'b0, "after_reset");

    // Exhaustive sweep against the golden LUT with random masks and randomness
    for (int i = 0; i < 256; i++) begin
      lut_si = 8'(i);
      #1;
      run_vec(8'(i), 8'($urandom), 8'($urandom), lut_so, 1'b0, "exhaustive");
    end

    // Fixed input, many mask splits: recombined value constant, share 0 must vary
    lut_si = 8'h3C;
    #1;
    for (int i = 0; i < 64; i++) begin
      run_vec(8'h3C, 8'($urandom), 8'($urandom), lut_so, 1'b1, "s3C_masks");
    end
    varied = 1'b0;
    foreach (rec_q[i]) if (rec_q[i] !== rec_q[0]) varied = 1'b1;
    n_checks++;
    if (!varied || rec_q.size() != 64) begin
      n_fail++;
      $display("FAIL share0_varies: varied=%0b samples=%0d expected varied=1 samples=64",
               varied, rec_q.size());
    end

`ifdef SKINNY_SBOX_DONE_EN
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_early: edge %0d done=%b expected 0", i, done);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_edge8: done=%b expected 1", done);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_rst: done=%b expected 0", done);
    end
`endif

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
